// File: rtl/demux_user_accum.sv
// Per-user sample accumulator and user sequencer: walks users 0..num-1, sums len
// handshaked samples per user into a saturating 20-bit total and presents it on the user-end pulse.
module demux_user_accum #(
  parameter int MAX_USERS = 40
) (
  input  logic        i_core_clk,
  input  logic        i_rx_rst,
  input  logic        i_sched_start,
  input  logic [5:0]  i_user_num,
  input  logic [9:0]  i_user_len,
  input  logic        i_sample_valid,
  input  logic [11:0] i_sample,
  output logic        o_sample_ready,
  output logic        o_demux_user_start,
  output logic [5:0]  o_demux_user_idx,
  output logic        o_demux_user_end,
  output logic [19:0] o_rams,
  output logic        o_busy,
  output logic        o_batch_done,
  output logic        o_sat,
  output logic        o_cfg_err
);

  localparam logic [5:0]  MAX_U   = MAX_USERS[5:0];
  localparam logic [19:0] SUM_MAX = 20'hFFFFF;

  typedef enum logic [1:0] {S_IDLE, S_START, S_ACC, S_END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  num_q, num_d;
  logic [5:0]  idx_q, idx_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] rams_q, rams_d;
  logic        sat_q, sat_d;
  logic        cfg_err_q, cfg_err_d;
  logic [20:0] sum;
  logic [9:0]  cnt_inc;
  logic        cfg_ok;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rams_d    = rams_q;
    sat_d     = sat_q;
    cfg_err_d = 1'b0;
    sum       = {1'b0, acc_q} + {9'd0, i_sample};
    cnt_inc   = cnt_q + 10'd1;
    cfg_ok    = (i_user_num != 6'd0) && (i_user_num <= MAX_U);

    case (state_q)
      S_IDLE: begin
        if (i_sched_start) begin
          if (cfg_ok) begin
            num_d   = i_user_num;
            len_d   = i_user_len;
            sat_d   = 1'b0;
            idx_d   = 6'd0;
            state_d = S_START;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_START: begin
        acc_d = 20'd0;
        cnt_d = 10'd0;
        if (len_q == 10'd0) begin
          rams_d  = 20'd0;
          state_d = S_END;
        end else begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        if (i_sample_valid) begin
          cnt_d = cnt_inc;
          // A carry out of bit 19 means the true sum no longer fits: clamp and flag.
          if (sum[20]) begin
            acc_d = SUM_MAX;
            sat_d = 1'b1;
          end else begin
            acc_d = sum[19:0];
          end
          if (cnt_inc == len_q) begin
            rams_d  = acc_d;
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (idx_q == num_q - 6'd1) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q   <= S_IDLE;
      num_q     <= 6'd0;
      idx_q     <= 6'd0;
      len_q     <= 10'd0;
      cnt_q     <= 10'd0;
      acc_q     <= 20'd0;
      rams_q    <= 20'd0;
      sat_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rams_q    <= rams_d;
      sat_q     <= sat_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_sample_ready     = (state_q == S_ACC);
  assign o_demux_user_start = (state_q == S_START);
  assign o_demux_user_end   = (state_q == S_END);
  assign o_demux_user_idx   = idx_q;
  assign o_rams             = rams_q;
  assign o_busy             = (state_q != S_IDLE);
  assign o_batch_done       = (state_q == S_END) && (idx_q == num_q - 6'd1);
  assign o_sat              = sat_q;
  assign o_cfg_err          = cfg_err_q;

endmodule

// File: doc/demux_user_accum.md
# demux_user_accum

Per-user sample accumulator and user sequencer that sits directly upstream of the per-user 20-bit key register array. On each batch it walks users 0..N-1 in order. For each user it emits a one-cycle user-start pulse with the user index, then accumulates a fixed number of handshaked samples into a saturating 20-bit sum. It closes the user with a one-cycle user-end pulse, presenting the sum on the data bus in that same cycle so the array captures it.

## Interface
- MAX_USERS, 40, number of user slots supported downstream; legal i_user_num is 1..MAX_USERS.
- i_core_clk  in  1  single clock; all logic rising-edge.
- i_rx_rst  in  1  reset, synchronous, active-high.
- i_sched_start  in  1  batch start pulse; honoured only in IDLE.
- i_user_num  in  6  users in batch; latched on accepted i_sched_start.
- i_user_len  in  10  samples per user; latched on accepted i_sched_start.
- i_sample_valid  in  1  sample present.
- i_sample  in  12  unsigned sample magnitude.
- o_sample_ready  out  1  high only in ACC state; a sample is consumed when i_sample_valid && o_sample_ready.
- o_demux_user_start  out  1  one-cycle pulse at the start of each user.
- o_demux_user_idx  out  6  current user index; stable from START through END.
- o_demux_user_end  out  1  one-cycle pulse closing each user.
- o_rams  out  20  accumulated sum; valid whenever o_demux_user_end=1.
- o_busy  out  1  high in any state other than IDLE.
- o_batch_done  out  1  one-cycle pulse coincident with the last user's o_demux_user_end.
- o_sat  out  1  sticky; set when any user's sum saturates; cleared on the next accepted i_sched_start.
- o_cfg_err  out  1  one-cycle pulse when i_sched_start is rejected for bad config.

## Operation
- Reset values: state=IDLE. All outputs are 0, including o_demux_user_idx=0, o_rams=0, o_sat=0.
- FSM states: IDLE, START, ACC, END.
- IDLE:
  - i_sched_start with 1 <= i_user_num <= MAX_USERS: latch num and len, clear o_sat, idx=0, go to START.
  - i_sched_start with i_user_num=0 or >MAX_USERS: pulse o_cfg_err next cycle, stay in IDLE, leave o_sat unchanged.
- START (1 cycle): o_demux_user_start=1, accumulator cleared to 0, sample counter cleared.
  - latched len=0: go to END; user closes with o_rams=0.
  - otherwise: go to ACC.
- ACC: each accepted sample adds to the accumulator and increments the counter.
  - On the accepted sample that makes count==len, go to END.
  - Invalid cycles stall indefinitely; there is no timeout.
- Arithmetic: the sum is formed 21 bits wide. If the result exceeds 20'hFFFFF, the accumulator holds 20'hFFFFF and o_sat is set. Once saturated, the accumulator stays at 20'hFFFFF for the rest of that user.
- END (1 cycle): o_demux_user_end=1 and o_rams=final sum.
  - idx==num-1: o_batch_done=1, go to IDLE.
  - otherwise: idx+1, go to START.
- o_rams holds its last value outside END; consumers must only sample it on o_demux_user_end.
- i_sched_start in any state other than IDLE is ignored, with no error pulse.
- i_user_num and i_user_len changing mid-batch have no effect; the latched copies are used.
- Samples presented while o_sample_ready=0 are not consumed; upstream holds them.
- Reset mid-batch: the next cycle is IDLE with all outputs 0. No end pulse and no done pulse are emitted for the aborted user.

## Timing
- i_sched_start accepted at cycle T: START (user_start, idx=0) at T+1, o_sample_ready=1 from T+2.
- Final sample of a user accepted at cycle S: END at S+1.
- Next user's START at S+2; its first sample can be accepted at S+3. The gap between users is 2 cycles with ready low.
- len=0: START at T+1, END at T+2, next START at T+3.
- Minimum batch length with continuous valid: num*(len+2) cycles from T+1 to the last END inclusive.
- o_demux_user_start and o_demux_user_end are never high in the same cycle. idx changes only on the cycle after END.
- o_busy rises at T+1 and falls on the cycle after the last END.
- o_cfg_err rises at T+1 for a rejected start.

## Test plan
- Basic batch: num=3, len=4, continuous valid, samples 1,2,3,... -> user 0/1/2 o_rams = 10/26/42. Starts occur at T+1, T+7, T+13. o_batch_done coincides with the third end. o_sat=0.
- Backpressure: num=1, len=3, valid toggling 1-0-1-0-1 with values 100,200,300 -> o_rams=600; END exactly 1 cycle after the third accepted sample. Samples are never consumed in START or END.
- Saturation: num=2, len=1023, all samples 4095 -> both users o_rams=20'hFFFFF and o_sat=1. A subsequent batch with small values clears o_sat at its start and gives the correct sum.
- Config edges: num=0 -> o_cfg_err pulse with no start pulse. num=41 -> o_cfg_err. num=40, len=0 -> 40 start/end pairs with idx 0..39 and o_rams=0, done on idx 39.
- Ignored start: i_sched_start pulsed during ACC, with i_user_num changed to 5 -> batch continues with the original latched num, and no extra start pulse appears.
- Reset mid-ACC: i_rx_rst asserted for 1 cycle during user 1 -> all outputs 0 next cycle, no end or done pulse. A fresh batch afterwards starts again at idx=0.
